// File: rtl/scan_capture.sv
// rtl/scan_capture.sv - samples a multiplexed 7-digit active-low LED scan into stable per-digit frames
module scan_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] trans,
    input  logic [6:0] led7seg,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [6:0] seg5,
    output logic [6:0] seg6,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic       seq_err,
    output logic       err_multi,
    output logic       scan_lost
);

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } state_t;

    localparam logic [7:0]  SETTLE_M1  = 8'(SETTLE - 1);
    localparam logic [27:0] TIMEOUT_W  = 28'(TIMEOUT);
    localparam logic [6:0]  BLANK      = 7'b1111111;

    state_t      state;
    state_t      state_next;
    logic [2:0]  exp_idx;
    logic [2:0]  exp_next;

    logic [6:0]  trans_prev;
    logic [6:0]  led_prev;
    logic [7:0]  stable_cnt;
    logic [27:0] wd_cnt;
    logic        armed;
    logic [6:0]  shadow [7];
    logic [6:0]  seg_q [7];
    logic [6:0]  frame_new [7];

    logic        is_valid;
    logic        is_multi;
    logic [2:0]  digit;
    logic        trans_chg;
    logic        input_chg;
    logic        sample;
    logic        timeout_hit;
    logic        complete;
    logic        seq_err_next;
    logic        differs;

    always_comb begin
        is_valid = 1'b1;
        digit    = 3'd0;
        case (trans)
            7'b0111111: digit = 3'd0;
            7'b1011111: digit = 3'd1;
            7'b1101111: digit = 3'd2;
            7'b1110111: digit = 3'd3;
            7'b1111011: digit = 3'd4;
            7'b1111101: digit = 3'd5;
            7'b1111110: digit = 3'd6;
            default:    is_valid = 1'b0;
        endcase
    end

    assign is_multi  = !is_valid && (trans != BLANK);
    assign trans_chg = (trans != trans_prev);
    assign input_chg = trans_chg || (led7seg != led_prev);

    // A changing cycle never samples, even if the counter still holds SETTLE-1 from the last dwell.
    assign sample      = !input_chg && armed && is_valid && (stable_cnt == SETTLE_M1);
    assign timeout_hit = !sample && (wd_cnt == TIMEOUT_W - 28'd1);

    always_comb begin
        state_next   = state;
        exp_next     = exp_idx;
        complete     = 1'b0;
        seq_err_next = 1'b0;
        if (sample) begin
            case (state)
                IDLE: begin
                    if (digit == 3'd0) begin
                        state_next = COLLECT;
                        exp_next   = 3'd1;
                    end
                end
                COLLECT: begin
                    if (digit == exp_idx) begin
                        if (digit == 3'd6) begin
                            complete   = 1'b1;
                            state_next = IDLE;
                            exp_next   = 3'd0;
                        end else begin
                            exp_next = digit + 3'd1;
                        end
                    end else begin
                        seq_err_next = 1'b1;
                        if (digit == 3'd0) begin
                            exp_next = 3'd1;
                        end else begin
                            state_next = IDLE;
                            exp_next   = 3'd0;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    exp_next   = 3'd0;
                end
            endcase
        end else if (timeout_hit) begin
            state_next = IDLE;
            exp_next   = 3'd0;
        end
    end

    // Digit 6 is written to the outputs in the same edge it lands in its shadow slot.
    always_comb begin
        differs = 1'b0;
        for (int i = 0; i < 7; i++) begin
            frame_new[i] = (sample && (digit == 3'(i))) ? led7seg : shadow[i];
            differs      = differs | (frame_new[i] != seg_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            exp_idx <= 3'd0;
        end else begin
            state   <= state_next;
            exp_idx <= exp_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trans_prev    <= BLANK;
            led_prev      <= BLANK;
            stable_cnt    <= 8'd0;
            wd_cnt        <= 28'd0;
            armed         <= 1'b1;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            seq_err       <= 1'b0;
            err_multi     <= 1'b0;
            scan_lost     <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                shadow[i] <= BLANK;
                seg_q[i]  <= BLANK;
            end
        end else begin
            trans_prev <= trans;
            led_prev   <= led7seg;

            if (input_chg) begin
                stable_cnt <= 8'd0;
            end else if (stable_cnt != 8'hff) begin
                stable_cnt <= stable_cnt + 8'd1;
            end

            if (trans_chg) begin
                armed <= 1'b1;
            end else if (sample) begin
                armed <= 1'b0;
            end

            if (sample) begin
                wd_cnt         <= 28'd0;
                shadow[digit]  <= led7seg;
            end else if (wd_cnt != TIMEOUT_W) begin
                wd_cnt <= wd_cnt + 28'd1;
            end

            frame_valid   <= complete;
            frame_changed <= complete && differs;
            seq_err       <= seq_err_next;
            err_multi     <= trans_chg && is_multi;

            if (complete) begin
                for (int i = 0; i < 7; i++) begin
                    seg_q[i] <= frame_new[i];
                end
            end

            if (complete) begin
                scan_lost <= 1'b0;
            end else if (timeout_hit) begin
                scan_lost <= 1'b1;
            end
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];

endmodule

// File: tb/tb_scan_capture.sv
// tb/tb_scan_capture.sv - randomized and directed bench for scan_capture against a dwell-level model
module tb_scan_capture;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] trans = 7'h7f;
    logic [6:0] led7seg = 7'h7f;
    logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6;
    logic       frame_valid, frame_changed, seq_err, err_multi, scan_lost;

    scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .trans(trans), .led7seg(led7seg),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6),
        .frame_valid(frame_valid), .frame_changed(frame_changed),
        .seq_err(seq_err), .err_multi(err_multi), .scan_lost(scan_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // observed pulses, recorded on the falling edge
    logic [49:0] mon_q[$];
    int mon_seq = 0, mon_multi = 0, mon_stray = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) mon_q.push_back({frame_changed, seg6, seg5, seg4, seg3, seg2, seg1, seg0});
            if (frame_changed && !frame_valid) mon_stray++;
            if (seq_err) mon_seq++;
            if (err_multi) mon_multi++;
        end
    end

    // reference model: works per dwell, tracking how many leading digits of a frame are collected
    logic [6:0]  m_prev = 7'h7f;
    int          m_prog = 0;
    logic [6:0]  m_buf [7];
    logic [48:0] m_last = '1;
    logic [49:0] exp_q[$];
    int exp_seq = 0, exp_multi = 0;

    function automatic logic [6:0] tr_of(input int k);
        return 7'h7f ^ (7'h40 >> k);
    endfunction

    function automatic int digit_of(input logic [6:0] t);
        for (int k = 0; k < 7; k++) if (t == tr_of(k)) return k;
        return -1;
    endfunction

    task automatic model_sample(input int k, input logic [6:0] l);
        logic [48:0] f;
        if (m_prog == 0) begin
            if (k == 0) begin m_buf[0] = l; m_prog = 1; end
        end else if (k == m_prog) begin
            m_buf[k] = l;
            m_prog++;
            if (m_prog == 7) begin
                f = {m_buf[6], m_buf[5], m_buf[4], m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                exp_q.push_back({f != m_last, f});
                m_last = f;
                m_prog = 0;
            end
        end else begin
            exp_seq++;
            if (k == 0) begin m_buf[0] = l; m_prog = 1; end
            else m_prog = 0;
        end
    endtask

    task automatic model_dwell(input logic [6:0] t, input logic [6:0] l, input int n);
        int k;
        k = digit_of(t);
        if (t != m_prev && k < 0 && t != 7'h7f) exp_multi++;
        if (k >= 0 && t != m_prev && n >= SETTLE + 1) model_sample(k, l);
        m_prev = t;
    endtask

    task automatic dwell(input logic [6:0] t, input logic [6:0] l, input int n);
        model_dwell(t, l, n);
        trans = t;
        led7seg = l;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [48:0] p, input int n);
        for (int k = 0; k < 7; k++) dwell(tr_of(k), p[k*7 +: 7], n);
    endtask

    task automatic frame_latency(input logic [48:0] p);
        int lat;
        lat = -1;
        for (int k = 0; k < 6; k++) dwell(tr_of(k), p[k*7 +: 7], 40);
        model_dwell(tr_of(6), p[42 +: 7], SETTLE + 6);
        trans = tr_of(6);
        led7seg = p[42 +: 7];
        for (int i = 0; i < SETTLE + 6; i++) begin
            @(negedge clk);
            if (frame_valid && lat < 0) lat = i;
            @(posedge clk); #1;
        end
        check("latency", lat, SETTLE + 1);
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        check({tag, "_nframes_model"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) check({tag, "_frame"}, mon_q[i], exp_q[i]);
        check({tag, "_seqerr_model"}, mon_seq, exp_seq);
        check({tag, "_multi_model"}, mon_multi, exp_multi);
        mon_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_segs"}, {seg6, seg5, seg4, seg3, seg2, seg1, seg0}, {49{1'b1}});
        check({tag, "_flags"}, {frame_valid, frame_changed, seq_err, err_multi, scan_lost}, 5'b0);
    endtask

    function automatic logic [49:0] last_frame();
        return (mon_q.size() > 0) ? mon_q[mon_q.size() - 1] : '0;
    endfunction

    logic [48:0] p1, p2, p3;
    int s0, m0;

    initial begin
        p1 = {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        p3 = {7'h02, 7'h12, 7'h19, 7'h78, 7'h24, 7'h79, 7'h40};
        p2 = {7'h10, 7'h00, 7'h03, 7'h46, 7'h21, 7'h06, 7'h4f};

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        dwell(7'h7f, 7'h7f, 5);

        // in-order scan
        frame(p1, 50);
        dwell(7'h7f, 7'h7f, 10);
        check("inorder_n", mon_q.size(), 1);
        check("inorder_frame", last_frame(), {1'b1, p1});
        check("inorder_seg0", seg0, 7'h40);
        check("inorder_seqerr", mon_seq, 0);
        compare_all("inorder");

        // identical frame, then digit 3 changed with latency measurement
        frame(p1, 50);
        dwell(7'h7f, 7'h7f, 10);
        check("repeat_frame", last_frame(), {1'b0, p1});
        frame_latency(p3);
        dwell(7'h7f, 7'h7f, 10);
        check("changed_frame", last_frame(), {1'b1, p3});
        check("changed_seg3", seg3, 7'h78);
        compare_all("repeat");

        // short dwell on digit 2 is not sampled, so digit 3 is out of order
        s0 = mon_seq;
        dwell(tr_of(0), p1[0 +: 7], 50);
        dwell(tr_of(1), p1[7 +: 7], 50);
        dwell(tr_of(2), p1[14 +: 7], SETTLE - 1);
        dwell(tr_of(3), p1[21 +: 7], 50);
        dwell(7'h7f, 7'h7f, 10);
        check("glitch_seqerr", mon_seq - s0, 1);
        check("glitch_n", mon_q.size(), 0);
        s0 = mon_seq;
        for (int k = 0; k < 7; k++) dwell(tr_of(k), p2[k*7 +: 7], (k == 2) ? 200 : 50);
        dwell(7'h7f, 7'h7f, 10);
        check("longdwell_seqerr", mon_seq - s0, 0);
        check("longdwell_frame", last_frame(), {1'b1, p2});
        compare_all("settle");

        // order faults
        s0 = mon_seq;
        dwell(tr_of(0), 7'h11, 50);
        dwell(tr_of(1), 7'h22, 50);
        dwell(tr_of(3), 7'h33, 50);
        check("order_skip_seqerr", mon_seq - s0, 1);
        frame(p1, 50);
        dwell(tr_of(0), 7'h55, 50);
        dwell(tr_of(1), 7'h66, 50);
        dwell(tr_of(0), p3[0 +: 7], 50);
        check("order_restart_seqerr", mon_seq - s0, 2);
        for (int k = 1; k < 7; k++) dwell(tr_of(k), p3[k*7 +: 7], 50);
        dwell(7'h7f, 7'h7f, 10);
        check("order_n", mon_q.size(), 2);
        check("order_restart_frame", last_frame(), {1'b1, p3});
        compare_all("order");

        // multi-select and scan loss
        m0 = mon_multi;
        dwell(7'b0011111, 7'h00, 10);
        dwell(7'h7f, 7'h7f, 10);
        check("multi_pulses", mon_multi - m0, 1);
        check("multi_n", mon_q.size(), 0);
        check("lost_before", scan_lost, 1'b0);
        dwell(7'h7f, 7'h7f, TIMEOUT + 20);
        m_prog = 0;
        check("lost_set", scan_lost, 1'b1);
        frame(p2, 40);
        dwell(7'h7f, 7'h7f, 10);
        check("lost_cleared", scan_lost, 1'b0);
        check("lost_n", mon_q.size(), 1);
        compare_all("lost");

        // reset mid-frame
        for (int k = 0; k < 5; k++) dwell(tr_of(k), p1[k*7 +: 7], 50);
        rst_n = 1'b0;
        trans = 7'h7f;
        led7seg = 7'h7f;
        #1;
        check_reset("midreset_async");
        repeat (2) begin @(posedge clk); #1; end
        check_reset("midreset_held");
        m_prog = 0;
        m_last = '1;
        m_prev = 7'h7f;
        rst_n = 1'b1;
        dwell(7'h7f, 7'h7f, 5);
        frame(p2, 40);
        dwell(7'h7f, 7'h7f, 10);
        check("postreset_frame", last_frame(), {1'b1, p2});
        compare_all("midreset");

        // randomized dwells
        begin
            int gap;
            gap = 0;
            for (int n = 0; n < 300; n++) begin
                int r, len, k;
                logic [6:0] t, l;
                r = $urandom_range(0, 99);
                if (r < 70) begin
                    k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : m_prog;
                    t = tr_of(k);
                end else if (r < 85) begin
                    t = 7'h7f;
                end else begin
                    t = 7'($urandom) & 7'($urandom);
                    while ($countones(t) > 5) t = 7'($urandom) & 7'($urandom);
                end
                if (t == m_prev) t = (m_prev == 7'h7f) ? tr_of(0) : 7'h7f;
                len = ($urandom_range(0, 2) != 0) ? $urandom_range(SETTLE + 1, SETTLE + 30)
                                                  : $urandom_range(1, SETTLE);
                if (!(digit_of(t) >= 0 && len >= SETTLE + 1) && gap + len > TIMEOUT / 2) begin
                    t = (tr_of(m_prog) != m_prev) ? tr_of(m_prog) : tr_of((m_prog + 1) % 7);
                    len = SETTLE + 5;
                end
                if (digit_of(t) >= 0 && len >= SETTLE + 1) gap = 0;
                else gap += len;
                l = 7'($urandom);
                dwell(t, l, len);
            end
        end
        dwell(7'h7f, 7'h7f, 30);
        check("random_lost", scan_lost, 1'b0);
        compare_all("random");
        check("stray_changed", mon_stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_capture.md
SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 16: clk cycles that trans and led7seg must hold unchanged before a digit is sampled (range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 200000: clk cycles without a sample before scan_lost asserts (range 2..2^28-1).
REQ-003 clk  in  1  rising-edge clock, single domain.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 trans  in  7  active-low digit select; digit k is active when trans is 7'b0111111 >> k with the vacated MSBs filled with 1 (k=0: 0111111, k=6: 1111110).
REQ-006 led7seg  in  7  active-low segment pattern for the active digit.
REQ-007 seg0..seg6  out  7 each  last complete captured frame, one output per digit.
REQ-008 frame_valid  out  1  one-cycle pulse when seg0..seg6 update.
REQ-009 frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous one.
REQ-010 seq_err  out  1  one-cycle pulse on a digit sampled out of order.
REQ-011 err_multi  out  1  one-cycle pulse on entry into a trans value with two or more low bits.
REQ-012 scan_lost  out  1  level; scan activity absent.

Function
REQ-013 Decode trans as: VALID(k) = exactly one low bit at position k per REQ-005; BLANK = 7'b1111111; MULTI = any other value.
REQ-014 Stability counter: SHALL clear whenever trans or led7seg differs from its value on the previous cycle; otherwise SHALL increment, saturating.
REQ-015 Sample event: SHALL fire in the cycle the stability counter reaches SETTLE-1 while trans is VALID(k) and the armed flag is set; the sample SHALL capture led7seg into shadow slot k.
REQ-016 Armed flag: SHALL clear on a sample event; SHALL set on any change of trans. Exactly one sample per digit dwell, regardless of dwell length.
REQ-017 BLANK and MULTI SHALL never produce a sample. err_multi SHALL pulse once on the first cycle of each MULTI dwell.
REQ-018 FSM states: IDLE and COLLECT, with expected index exp (3 bits).
REQ-019 IDLE: a sample of digit 0 -> COLLECT, exp=1. A sample of any other digit SHALL be ignored, with no error.
REQ-020 COLLECT: a sample of k==exp with k<6 -> exp=k+1.
REQ-021 COLLECT: a sample of k==6==exp SHALL complete the frame, and in the next cycle SHALL:
- copy shadow slots 0..6 to seg0..seg6;
- pulse frame_valid;
- pulse frame_changed if any slot differs from the prior output value;
- then -> IDLE.
REQ-022 COLLECT: a sample of k!=exp SHALL pulse seq_err; if k==0 -> COLLECT with exp=1, else -> IDLE.
REQ-023 seg0..seg6 SHALL change only per REQ-021; partial frames are never visible.
REQ-024 Watchdog counter: SHALL clear on every sample event; otherwise SHALL increment, saturating at TIMEOUT.
REQ-025 Reaching TIMEOUT SHALL set scan_lost and force IDLE. scan_lost SHALL clear only on the next frame_valid.
REQ-026 Simultaneous timeout and sample in one cycle: the sample SHALL win; watchdog clears; no scan_lost.
REQ-027 Frame latency: frame_valid SHALL assert SETTLE+1 cycles after digit 6's final input change.

Reset
REQ-028 While rst_n=0, the following SHALL hold:
- seg0..seg6 = 7'b1111111;
- frame_valid, frame_changed, seq_err, err_multi = 0;
- scan_lost = 0;
- FSM = IDLE, exp = 0;
- counters = 0, armed = 1, shadow = 7'b1111111.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame. After release, the first frame_changed compares against all-1s outputs.
REQ-030 The previous-cycle trans/led7seg registers SHALL reset to 7'b1111111 (BLANK), so no spurious err_multi or sample occurs at release.

Verification
REQ-031 In-order scan: digits 0..6 with patterns 40,79,24,30,19,12,02 (hex), dwell 50 cycles each -> one frame_valid; seg0..seg6 equal those patterns; frame_changed=1; no errors.
REQ-032 Repeat identical frame -> frame_valid=1, frame_changed=0. Change digit 3 to 7'h78 -> frame_changed=1.
REQ-033 Glitch/settle: dwell of SETTLE-1 cycles on digit 2 -> no sample, and the next digit-3 sample gives seq_err; dwell of 200 cycles -> exactly one sample.
REQ-034 Order fault: 0,1,3 -> seq_err on the digit-3 sample, FSM IDLE. Then 0..6 -> valid frame. 0,1,0 -> seq_err, COLLECT exp=1.
REQ-035 trans=7'b0011111 for 10 cycles -> a single err_multi pulse, no sample. trans held BLANK for TIMEOUT cycles -> scan_lost=1; next complete frame -> scan_lost=0.
REQ-036 rst_n low after digit 4 -> outputs at reset values. Next full frame -> frame_valid, frame_changed=1.
